// File: rtl/arith_pkg.sv
// Shared state encodings and helpers for the sequential arithmetic units.
// Encodings are plain localparams so the state bus can be exported as a debug port.
package arith_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StDiv  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [1:0] StMulIdle = 2'd0;
  localparam logic [1:0] StMulRun  = 2'd1;
  localparam logic [1:0] StMulDone = 2'd2;

  // Width of a down-counter that must hold the value n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, compare with
// the divisor and subtract when the shifted remainder is not smaller.
module div_step #(
  parameter int unsigned N = 256
) (
  input  logic [N-1:0] rem_i,
  input  logic         dvd_msb_i,
  input  logic [N-1:0] divisor_i,
  output logic         q_bit_o,
  output logic [N-1:0] rem_o
);

  logic [N:0]   shifted;
  logic [N-1:0] diff;

  always_comb begin
    shifted = {rem_i, dvd_msb_i};
    q_bit_o = (shifted >= {1'b0, divisor_i});
    // A taken subtract always leaves a value below the divisor, so N bits suffice.
    diff    = shifted[N-1:0] - divisor_i;
    rem_o   = q_bit_o ? diff : shifted[N-1:0];
  end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned divider: one quotient bit per cycle, MSB first, with
// a registered result that is held until the next accepted start.
module seq_div
  import arith_pkg::*;
#(
  parameter int unsigned N = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] quot,
  output logic [N-1:0] rem,
  output logic         data_rdy,
  output logic         busy,
  output logic         div_by_zero,
  output logic [1:0]   state
);

  localparam int unsigned CntW = cnt_width(N);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    dvd_q, dvd_d;      // dividend shifting out, quotient shifting in
  logic [N-1:0]    dsr_q, dsr_d;
  logic [N-1:0]    prem_q, prem_d;
  logic [N-1:0]    quot_q, quot_d;
  logic [N-1:0]    rem_q, rem_d;
  logic            rdy_q, rdy_d;
  logic            dbz_q, dbz_d;

  logic            step_q_bit;
  logic [N-1:0]    step_rem;

  div_step #(
    .N(N)
  ) u_div_step (
    .rem_i     (prem_q),
    .dvd_msb_i (dvd_q[N-1]),
    .divisor_i (dsr_q),
    .q_bit_o   (step_q_bit),
    .rem_o     (step_rem)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    prem_d  = prem_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    rdy_d   = rdy_q;
    dbz_d   = dbz_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StDiv;
          cnt_d   = CntW'(N);
          dvd_d   = a;
          dsr_d   = b;
          prem_d  = '0;
          rdy_d   = 1'b0;
          dbz_d   = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      StDiv: begin
        dvd_d  = {dvd_q[N-2:0], step_q_bit};
        prem_d = step_rem;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
          quot_d  = {dvd_q[N-2:0], step_q_bit};
          rem_d   = step_rem;
          rdy_d   = 1'b1;
          dbz_d   = (dsr_q == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      prem_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      rdy_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      prem_q  <= prem_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      rdy_q   <= rdy_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quot        = quot_q;
  assign rem         = rem_q;
  assign data_rdy    = rdy_q;
  assign busy        = (state_q == StDiv);
  assign div_by_zero = dbz_q;
  assign state       = state_q;

endmodule
